// File: rtl/led_bar_pkg.sv
// rtl/led_bar_pkg.sv - shared widths and peak-hold state encoding for the LED bargraph
// Contents: LEVEL_W (activity level width), DUTY_W (PWM step width), peak_state_e.
package led_bar_pkg;

    localparam int LEVEL_W = 6;
    localparam int DUTY_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } peak_state_e;

endpackage

// File: rtl/led_pwm_gen.sv
// rtl/led_pwm_gen.sv - free-running prescaler and 4-bit PWM step counter
// Ports:
//   clk_i   - system clock
//   rst_i   - asynchronous active-high reset
//   pwm_cnt - current PWM step 0..15, advances once every PWM_PRESCALE clocks
module led_pwm_gen
    import led_bar_pkg::*;
#(
    parameter int PWM_PRESCALE = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic [DUTY_W-1:0] pwm_cnt
);

    localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PWM_PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;

    // With PWM_PRESCALE == 1 the prescaler sits at 0 and pwm_cnt steps every clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (pre_cnt == PRE_MAX) begin
            pre_cnt <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_bargraph_driver.sv
// rtl/led_bargraph_driver.sv - LED bar display of the 6-bit activity level with PWM partial LED and peak marker
// Optional feature macro: LED_BARGRAPH_PEAK_HOLD_EN (peak-hold FSM and marker LED).
// Ports:
//   clk_i         - system clock
//   rst_i         - asynchronous active-high reset
//   level_valid_i - single-cycle strobe qualifying level6_i
//   level6_i      - activity level 0..63
//   enable_i      - display enable, low blanks led_o
//   led_o         - registered LED drive, bit 0 = bottom of bar
//   peak_o        - current peak-hold value (0 when the peak feature is not built)
module led_bargraph_driver
    import led_bar_pkg::*;
#(
    parameter int NUM_LEDS      = 6,
    parameter int PWM_PRESCALE  = 256,
    parameter int HOLD_UPDATES  = 512,
    parameter int DECAY_UPDATES = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                level_valid_i,
    input  logic [LEVEL_W-1:0]  level6_i,
    input  logic                enable_i,
    output logic [NUM_LEDS-1:0] led_o,
    output logic [LEVEL_W-1:0]  peak_o
);

    localparam int IDX_W    = $clog2(NUM_LEDS + 1);
    localparam int SCALED_W = LEVEL_W + IDX_W;
    localparam logic [SCALED_W-1:0] NUM_LEDS_S = SCALED_W'(NUM_LEDS);

    logic [LEVEL_W-1:0]  level_q;
    logic [DUTY_W-1:0]   pwm_cnt;
    logic [SCALED_W-1:0] scaled;
    logic [IDX_W-1:0]    full;
    logic [DUTY_W-1:0]   duty;
    logic [1:0]          scaled_unused;
    logic [NUM_LEDS-1:0] bar;
    logic [NUM_LEDS-1:0] marker;

    led_pwm_gen #(
        .PWM_PRESCALE(PWM_PRESCALE)
    ) u_pwm (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pwm_cnt(pwm_cnt)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q <= '0;
        end else if (level_valid_i) begin
            level_q <= level6_i;
        end
    end

    // level*NUM_LEDS/64: integer part selects the partial LED, next 4 bits are its duty.
    assign scaled = SCALED_W'(level_q) * NUM_LEDS_S;
    assign {full, duty, scaled_unused} = scaled;

    always_comb begin
        bar = '0;
        for (int k = 0; k < NUM_LEDS; k++) begin
            if (IDX_W'(k) < full) begin
                bar[k] = 1'b1;
            end else if ((IDX_W'(k) == full) && (pwm_cnt < duty)) begin
                bar[k] = 1'b1;
            end
        end
    end

`ifdef LED_BARGRAPH_PEAK_HOLD_EN
    localparam int HOLD_W  = (HOLD_UPDATES > 1) ? $clog2(HOLD_UPDATES) : 1;
    localparam int DECAY_W = (DECAY_UPDATES > 1) ? $clog2(DECAY_UPDATES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_UPDATES - 1);
    localparam logic [DECAY_W-1:0] DECAY_LOAD = DECAY_W'(DECAY_UPDATES - 1);

    peak_state_e         state;
    logic [LEVEL_W-1:0]  peak_q;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [DECAY_W-1:0]  decay_cnt;
    logic [SCALED_W-1:0] peak_scaled;
    logic [IDX_W-1:0]    peak_idx;
    logic [LEVEL_W-1:0]  peak_frac_unused;

    // Only accepted updates advance the FSM; the time base is the update stream.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            peak_q    <= '0;
            hold_cnt  <= '0;
            decay_cnt <= '0;
        end else if (level_valid_i) begin
            if ((level6_i >= peak_q) && (level6_i != '0)) begin
                peak_q   <= level6_i;
                hold_cnt <= HOLD_LOAD;
                state    <= HOLD;
            end else begin
                case (state)
                    HOLD: begin
                        if (hold_cnt == '0) begin
                            state     <= DECAY;
                            decay_cnt <= DECAY_LOAD;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                    DECAY: begin
                        if (decay_cnt == '0) begin
                            peak_q    <= peak_q - 1'b1;
                            decay_cnt <= DECAY_LOAD;
                            if (peak_q == LEVEL_W'(1)) begin
                                state <= IDLE;
                            end
                        end else begin
                            decay_cnt <= decay_cnt - 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign peak_scaled = SCALED_W'(peak_q) * NUM_LEDS_S;
    assign {peak_idx, peak_frac_unused} = peak_scaled;

    // A zero peak means nothing is held, so no marker (otherwise LED0 would glow at idle).
    always_comb begin
        marker = '0;
        for (int k = 0; k < NUM_LEDS; k++) begin
            if ((peak_q != '0) && (IDX_W'(k) == peak_idx)) begin
                marker[k] = 1'b1;
            end
        end
    end

    assign peak_o = peak_q;
`else
    assign marker = '0;
    assign peak_o = '0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            led_o <= '0;
        end else begin
            led_o <= enable_i ? (bar | marker) : '0;
        end
    end

endmodule

// File: doc/led_bargraph_driver.md
# led_bargraph_driver

Drives a bar of discrete LEDs from the 6-bit activity level produced by the sampler's envelope stage. It is the display-side consumer of that level stream. Each level maps to a number of fully lit LEDs plus one PWM-dimmed partial LED. An optional peak-hold marker holds the recent maximum, then decays it. The block sits between the envelope stage and the board LED pins.

## Interface
- `NUM_LEDS`, default 6: number of LEDs in the bar, range 2..16.
- `PWM_PRESCALE`, default 256: clocks per PWM step, ≥ 1.
- `HOLD_UPDATES`, default 512: accepted level updates for which the peak is held, ≥ 1.
- `DECAY_UPDATES`, default 32: accepted level updates per 1-LSB peak decrement, ≥ 1.
- `clk_i` input 1: system clock. Single clock domain.
- `rst_i` input 1: reset, asynchronous assert, active-high.
- `level_valid_i` input 1: single-cycle strobe; qualifies `level6_i`.
- `level6_i` input 6: activity level 0..63, unsigned.
- `enable_i` input 1: display enable. Low blanks all LEDs.
- `led_o` output NUM_LEDS: LED drive, active-high. Bit 0 is the bottom of the bar.
- `peak_o` output 6: current peak-hold value, for debug.

## Operation
- Level capture:
  - `level_q` loads `level6_i` when `level_valid_i` is high. Otherwise it holds.
- Quantization, unsigned:
  - `scaled = level_q * NUM_LEDS`, width 6+clog2(NUM_LEDS+1).
  - `full = scaled >> 6`, giving 0..NUM_LEDS-1.
  - `duty = scaled[5:2]`, giving 0..15.
- Bar mapping:
  - LED k with k < `full` is on.
  - LED `full` is on when `pwm_cnt < duty`. Duty 0 means off. Duty never produces 100 %.
  - LEDs with index > `full` are off.
- PWM:
  - The prescaler counts 0..PWM_PRESCALE-1.
  - On wrap, the 4-bit `pwm_cnt` increments, wrapping 15→0.
  - Both counters free-run, independent of `enable_i` and of level updates.
- Peak-hold FSM: states IDLE, HOLD, DECAY. It advances only on accepted updates (`level_valid_i`=1), comparing against `level6_i` in that same cycle.
  - Any state, `level6_i >= peak_q` and `level6_i != 0`:
    - `peak_q ← level6_i`
    - `hold_cnt ← HOLD_UPDATES-1`
    - go to HOLD.
    - This capture has priority over hold countdown and decay.
  - HOLD, otherwise:
    - If `hold_cnt == 0`, go to DECAY with `decay_cnt ← DECAY_UPDATES-1`.
    - Otherwise decrement `hold_cnt`.
  - DECAY, otherwise:
    - If `decay_cnt == 0`: `peak_q ← peak_q-1`, `decay_cnt ← DECAY_UPDATES-1`.
    - If that decrement reaches 0, go to IDLE.
    - Otherwise decrement `decay_cnt`.
  - IDLE: `peak_q` = 0. A level-0 update keeps IDLE.
- Peak marker:
  - LED `(peak_q*NUM_LEDS)>>6` is forced fully on.
  - It is ORed with the bar.
- Blanking: `enable_i` low forces `led_o` to 0. The FSM, `level_q` and the PWM counters continue unaffected.

## Timing
- Reset values: `led_o`=0, `peak_o`=0, `level_q`=0, FSM=IDLE, all counters 0.
- Reset takes effect asynchronously on assertion. Release is synchronous to `clk_i`.
- `level_valid_i` at edge t updates `level_q`, `peak_q` and the FSM at t.
- `led_o` is registered and reflects them after edge t+1. Total latency is 2 clocks.
- `enable_i` affects `led_o` after one edge.
- `peak_o` equals `peak_q`, with no extra register.
- Back-to-back valids on consecutive cycles are legal. Each one counts as an update.
- Reset asserted mid-hold or mid-decay abandons the state. After release the block starts from IDLE.

## Configuration
- Macro `LED_BARGRAPH_PEAK_HOLD_EN`.
- Defined: the peak-hold FSM, its counters and the marker are built as described above.
- Undefined:
  - No FSM or counters.
  - `peak_o` is tied to 0.
  - `led_o` shows the bar only.

## Structure
- Package `led_bar_pkg`:
  - `LEVEL_W`=6, `DUTY_W`=4.
  - `peak_state_e` enum {IDLE, HOLD, DECAY}.
- Sub-module `led_pwm_gen`:
  - Contains the prescaler and `pwm_cnt`.
  - Outputs `pwm_cnt`.
  - Parameter PWM_PRESCALE.
- The top level contains capture, quantization, the FSM and the output register.

## Test plan
All scenarios use NUM_LEDS=6, PWM_PRESCALE=4, HOLD_UPDATES=4 and DECAY_UPDATES=2.
- Reset: assert `rst_i` mid-DECAY. Required response: `led_o`=0 and `peak_o`=0 before the next edge. After release, FSM is IDLE.
- Level 32: `scaled` is 192, so `full`=3 and `duty`=0. Required response: `led_o`=6'b001111 steady (marker on LED3). Without the macro, 6'b000111.
- Level 40: `duty`=12. Required response: LEDs 0-2 steady. LED3 on for 12 of every 16 PWM steps, i.e. 48 on out of every 64 clocks.
- Level 63: `full`=5 and `duty`=14. Required response: LEDs 0-4 on. LED5 steady through the marker. Without the macro, LED5 is at 14/16 duty.
- Peak decay: one update at 63, then updates of 0 every cycle. Required response:
  - `peak_o`=63 for 4 further updates.
  - Then `peak_o` drops by 1 every 2 updates until it reaches 0, then the FSM is IDLE.
  - An update of 50 while `peak_o`=40 sets `peak_o`=50 and enters HOLD.
- Enable: `enable_i`=0 with level 63. Required response: `led_o`=0 one edge later. `peak_o` is unaffected.
